// File: rtl/mc_controller.sv
// Multi-cycle instruction sequencer: walks IF/ID/EXE/MEM/WB per instruction and
// drives the datapath strobes combinationally from the current state.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCwrt,
    output logic       IRwrt,
    output logic       regWrt,
    output logic       memToReg,
    output logic       ALUsrcA,
    output logic       ALUsrcB,
    output logic       extOp,
    output logic       memWrt,
    output logic       memRd,
    output logic       jump,
    output logic       branch,
    output logic [2:0] ALUctr,
    output logic [2:0] state,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;

    state_t     st;
    state_t     st_nxt;
    logic [5:0] op_q;
    logic [5:0] funct_q;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLL);
    endfunction

    // Opcodes that proceed into EXE; j and halt are resolved in ID itself.
    function automatic logic goes_to_exe(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_RTYPE:                              return funct_ok(f);
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI,
            OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_sel(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_RTYPE: begin
                case (f)
                    FN_SUB:  return 3'b001;
                    FN_SLL:  return 3'b010;
                    FN_OR:   return 3'b011;
                    FN_AND:  return 3'b100;
                    default: return 3'b000;
                endcase
            end
            OP_BEQ, OP_BNE:   return 3'b001;
            OP_ORI:           return 3'b011;
            OP_ANDI:          return 3'b100;
            OP_SLTI, OP_BLTZ: return 3'b110;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic logic ext_sel(input logic [5:0] o);
        return (o == OP_ANDI) || (o == OP_SW) || (o == OP_LW) ||
               (o == OP_BEQ)  || (o == OP_BNE) || (o == OP_BLTZ);
    endfunction

    function automatic logic is_branch(input logic [5:0] o);
        return (o == OP_BEQ) || (o == OP_BNE) || (o == OP_BLTZ);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= S_IF;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            st <= st_nxt;
            if (st == S_ID) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    always_comb begin
        st_nxt   = S_IF;
        PCwrt    = 1'b0;
        IRwrt    = 1'b0;
        regWrt   = 1'b0;
        memToReg = 1'b0;
        ALUsrcA  = 1'b0;
        ALUsrcB  = 1'b0;
        extOp    = 1'b0;
        memWrt   = 1'b0;
        memRd    = 1'b0;
        jump     = 1'b0;
        branch   = 1'b0;
        ALUctr   = 3'b000;

        // ALU operand controls stay stable for the whole execute/memory/writeback span.
        if (st == S_EXE || st == S_MEM || st == S_WB) begin
            ALUctr  = alu_sel(op_q, funct_q);
            ALUsrcA = !(op_q == OP_RTYPE && funct_q == FN_SLL);
            ALUsrcB = (op_q == OP_RTYPE);
            extOp   = ext_sel(op_q);
        end

        case (st)
            S_IF: begin
                IRwrt  = 1'b1;
                st_nxt = S_ID;
            end
            S_ID: begin
                if (op == OP_J) begin
                    PCwrt  = 1'b1;
                    jump   = 1'b1;
                    st_nxt = S_IF;
                end else if (op == OP_HALT) begin
                    st_nxt = S_HALT;
                end else if (goes_to_exe(op, funct)) begin
                    st_nxt = S_EXE;
                end else begin
                    PCwrt  = 1'b1;
                    st_nxt = S_IF;
                end
            end
            S_EXE: begin
                if (is_branch(op_q)) begin
                    PCwrt  = 1'b1;
                    branch = (op_q == OP_BEQ) ? zero : ~zero;
                    st_nxt = S_IF;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    st_nxt = S_MEM;
                end else begin
                    st_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (op_q == OP_SW) begin
                    memWrt = 1'b1;
                    PCwrt  = 1'b1;
                    st_nxt = S_IF;
                end else if (op_q == OP_LW) begin
                    memRd  = 1'b1;
                    st_nxt = S_WB;
                end else begin
                    st_nxt = S_IF;
                end
            end
            S_WB: begin
                regWrt = 1'b1;
                PCwrt  = 1'b1;
                if (op_q == OP_LW) begin
                    memToReg = 1'b1;
                    memRd    = 1'b1;
                end
                st_nxt = S_IF;
            end
            S_HALT: st_nxt = S_HALT;
            default: st_nxt = S_IF;
        endcase
    end

    assign state  = st;
    assign halted = (st == S_HALT);

endmodule

// File: tb/tb_mc_controller.sv
// Randomized instruction stream against a per-instruction cycle-table model,
// plus directed cases with literal cycle counts and branch outcomes.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCwrt, IRwrt, regWrt, memToReg, ALUsrcA, ALUsrcB, extOp;
    logic       memWrt, memRd, jump, branch, halted;
    logic [2:0] ALUctr, state;

    int total = 0;
    int bad   = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCwrt(PCwrt), .IRwrt(IRwrt), .regWrt(regWrt), .memToReg(memToReg),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .extOp(extOp), .memWrt(memWrt),
        .memRd(memRd), .jump(jump), .branch(branch), .ALUctr(ALUctr),
        .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic hl, pc, ir, rw, m2r, sa, sb, ext, mw, mr, jp, br;
        logic [2:0] alu;
    } ov_t;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4, K_HALT = 5, K_NOP = 6;

    logic [11:0] itab [0:17] = '{
        {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
        {6'b000000, 6'b100101}, {6'b000000, 6'b000000}, {6'b001001, 6'b000000},
        {6'b001100, 6'b000000}, {6'b001101, 6'b000000}, {6'b001010, 6'b000000},
        {6'b101011, 6'b000000}, {6'b100011, 6'b000000}, {6'b000100, 6'b000000},
        {6'b000101, 6'b000000}, {6'b000001, 6'b000000}, {6'b000010, 6'b000000},
        {6'b111000, 6'b000000}, {6'b000000, 6'b101010}, {6'b111111, 6'b000000}
    };

    function automatic ov_t dut_out();
        ov_t r;
        r = {state, halted, PCwrt, IRwrt, regWrt, memToReg, ALUsrcA, ALUsrcB,
             extOp, memWrt, memRd, jump, branch, ALUctr};
        return r;
    endfunction

    // Instruction class and its ALU attributes, straight from the opcode table.
    function automatic void decode(input logic [5:0] o, input logic [5:0] f, output int kind,
                                   output logic [2:0] alu, output logic sa, output logic sb,
                                   output logic ext);
        kind = K_NOP; alu = 3'b000; sa = 1'b1; sb = 1'b0; ext = 1'b0;
        if (o == 6'b000000) begin
            sb = 1'b1;
            kind = K_ALU;
            case (f)
                6'b100000: alu = 3'b000;
                6'b100010: alu = 3'b001;
                6'b100100: alu = 3'b100;
                6'b100101: alu = 3'b011;
                6'b000000: begin alu = 3'b010; sa = 1'b0; end
                default:   kind = K_NOP;
            endcase
        end else begin
            case (o)
                6'b001001: kind = K_ALU;
                6'b001100: begin kind = K_ALU; alu = 3'b100; ext = 1'b1; end
                6'b001101: begin kind = K_ALU; alu = 3'b011; end
                6'b001010: begin kind = K_ALU; alu = 3'b110; end
                6'b101011: begin kind = K_SW; ext = 1'b1; end
                6'b100011: begin kind = K_LW; ext = 1'b1; end
                6'b000100, 6'b000101: begin kind = K_BR; alu = 3'b001; ext = 1'b1; end
                6'b000001: begin kind = K_BR; alu = 3'b110; ext = 1'b1; end
                6'b000010: kind = K_J;
                6'b111111: kind = K_HALT;
                default:   kind = K_NOP;
            endcase
        end
    endfunction

    function automatic int ilen(input int kind);
        case (kind)
            K_J, K_NOP: return 2;
            K_BR:       return 3;
            K_SW, K_ALU: return 4;
            K_LW:       return 5;
            default:    return 12;
        endcase
    endfunction

    // Expected outputs for cycle idx of an instruction (idx 0 = its fetch cycle).
    function automatic ov_t mdl(input logic [5:0] o, input logic [5:0] f, input int idx,
                                input logic z);
        ov_t e;
        int kind;
        logic [2:0] alu;
        logic sa, sb, ext;
        e = '0;
        decode(o, f, kind, alu, sa, sb, ext);
        if (idx == 0) begin
            e.ir = 1'b1;
            return e;
        end
        if (idx == 1) begin
            e.st = 3'b001;
            if (kind == K_J) begin e.pc = 1'b1; e.jp = 1'b1; end
            if (kind == K_NOP) e.pc = 1'b1;
            return e;
        end
        if (kind == K_HALT) begin
            e.st = 3'b101;
            e.hl = 1'b1;
            return e;
        end
        e.alu = alu; e.sa = sa; e.sb = sb; e.ext = ext;
        e.st = 3'b010;
        case (kind)
            K_ALU: if (idx == 3) begin e.st = 3'b100; e.rw = 1'b1; e.pc = 1'b1; end
            K_LW: begin
                if (idx == 3) begin e.st = 3'b011; e.mr = 1'b1; end
                if (idx == 4) begin
                    e.st = 3'b100; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; e.pc = 1'b1;
                end
            end
            K_SW: if (idx == 3) begin e.st = 3'b011; e.mw = 1'b1; e.pc = 1'b1; end
            K_BR: begin
                e.pc = 1'b1;
                e.br = (o == 6'b000100) ? z : ~z;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string nm, input ov_t got, input ov_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // Entered at posedge+1 of a fetch cycle; leaves at posedge+1 of the next fetch cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int abort_at, output int cpi, output logic br_seen);
        int kind, n;
        logic [2:0] alu;
        logic sa, sb, ext;
        decode(o, f, kind, alu, sa, sb, ext);
        n = ilen(kind);
        cpi = 0;
        br_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i <= 1) begin
                op = o; funct = f;
            end else begin
                op = 6'($urandom); funct = 6'($urandom);
            end
            zero = (zmode == 0) ? 1'($urandom) : (zmode == 1);
            @(negedge clk);
            check("seq", dut_out(), mdl(o, f, i, zero));
            if (PCwrt && cpi == 0) cpi = i + 1;
            if (i == 2) br_seen = branch;
            if (i == abort_at) begin
                #2 reset = 1'b1;
                #1 check("rst_async", dut_out(), mdl(o, f, 0, zero));
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (kind == K_HALT) begin
            reset = 1'b1;
            #1 check("rst_halt", dut_out(), mdl(o, f, 0, zero));
            @(posedge clk);
            #1 reset = 1'b0;
        end
    endtask

    initial begin
        int cpi, pick, abort_at;
        logic br;
        logic [5:0] ro, rf;
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        #3 check("reset_hold", dut_out(), mdl(6'd0, 6'd0, 0, 1'b0));
        @(posedge clk);
        #1 check("reset_edge", dut_out(), mdl(6'd0, 6'd0, 0, 1'b0));
        reset = 1'b0;

        run_instr(6'b000000, 6'b100000, 0, -1, cpi, br); check_int("cpi_add", cpi, 4);
        run_instr(6'b100011, 6'b000000, 0, -1, cpi, br); check_int("cpi_lw", cpi, 5);
        run_instr(6'b000100, 6'b000000, 1, -1, cpi, br); check_int("cpi_beq1", cpi, 3);
        check_int("beq_z1_branch", int'(br), 1);
        run_instr(6'b000100, 6'b000000, 2, -1, cpi, br); check_int("cpi_beq0", cpi, 3);
        check_int("beq_z0_branch", int'(br), 0);
        run_instr(6'b000101, 6'b000000, 2, -1, cpi, br); check_int("bne_z0_branch", int'(br), 1);
        run_instr(6'b000010, 6'b000000, 0, -1, cpi, br); check_int("cpi_j", cpi, 2);
        run_instr(6'b101011, 6'b000000, 0, 3, cpi, br);  check_int("sw_abort_memwrt", int'(memWrt), 0);
        run_instr(6'b101011, 6'b000000, 0, -1, cpi, br); check_int("cpi_sw", cpi, 4);
        run_instr(6'b111000, 6'b000000, 0, -1, cpi, br); check_int("cpi_nop_op", cpi, 2);
        run_instr(6'b000000, 6'b101010, 0, -1, cpi, br); check_int("cpi_nop_fn", cpi, 2);
        run_instr(6'b001001, 6'b000000, 0, -1, cpi, br); check_int("cpi_addiu", cpi, 4);
        run_instr(6'b111111, 6'b000000, 0, -1, cpi, br); check_int("halt_no_pc", cpi, 0);

        for (int k = 0; k < 500; k++) begin
            pick = $urandom_range(0, 18);
            if (pick == 17 && $urandom_range(0, 3) != 0) pick = $urandom_range(0, 16);
            if (pick == 18) begin
                ro = 6'($urandom); rf = 6'($urandom);
                if (ro == 6'b111111) ro = 6'b111110;
            end else begin
                ro = itab[pick][11:6]; rf = itab[pick][5:0];
            end
            abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(ro, rf, 0, abort_at, cpi, br);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
